ibuf_conditioner: RTL and testbench
===================================

Name: ibuf_conditioner

Overview:
- Input-buffer block for external pins such as the oscillator input and ZIF sense pins.
- Passes the pad level straight through, like a primitive input buffer.
- Also gives clocked conditioned views of the pin: synchronized, deglitched, rise/fall pulses and a saturating rising-edge counter.
- Sits between the FPGA pads and the programmer state machines.

Parameters:
- WIDTH, 1, number of independent input bits.
- SYNC_STAGES, 2, synchronizer flops per bit; minimum 2.
- FILTER_LEN, 6, consecutive clock cycles a new level must hold before it is accepted (6 cycles = 250 ns at 24 MHz); minimum 1.
- CNT_WIDTH, 16, width of the edge counter.

Ports:
- osc  input  1  system clock (24 MHz oscillator domain); all registers use its rising edge.
- rst  input  1  asynchronous, active-high reset.
- I  input  WIDTH  raw pad inputs; asynchronous to osc.
- O  output  WIDTH  buffered pad level.
- o_sync  output  WIDTH  synchronized level.
- o_filt  output  WIDTH  deglitched level.
- rise  output  WIDTH  one-cycle pulse on each 0->1 change of o_filt.
- fall  output  WIDTH  one-cycle pulse on each 1->0 change of o_filt.
- clr  input  1  synchronous clear of edge_cnt.
- edge_cnt  output  CNT_WIDTH  saturating count of cycles with any rise bit set.

Behaviour:
- O = I, purely combinational, no clock and no reset dependency.
- Synchronizer:
  - Per bit, a chain of SYNC_STAGES flops.
  - o_sync is the last stage.
  - A change on I appears on o_sync after exactly SYNC_STAGES rising edges of osc.
- Deglitch filter:
  - Per bit: o_filt register plus a counter sized for FILTER_LEN.
  - Each cycle with o_sync == o_filt clears the counter.
  - Each cycle with o_sync != o_filt increments the counter.
  - On the FILTER_LEN-th consecutive mismatching cycle, o_filt takes o_sync and the counter clears.
  - Pulses shorter than FILTER_LEN cycles (measured after sync) never reach o_filt.
  - Bits are fully independent.
- Edge detect:
  - filt_q is o_filt delayed one cycle.
  - rise = o_filt & ~filt_q; fall = ~o_filt & filt_q.
  - Each pulse lasts exactly one cycle.
  - rise and fall are never both set on the same bit.
- Counter:
  - edge_cnt increments by 1 in any cycle where rise is nonzero.
  - Multiple rising bits in one cycle still count +1.
  - Saturates at all-ones; no wrap.
  - clr = 1 forces edge_cnt to 0 on the next edge and overrides a simultaneous increment.
- Reset:
  - rst = 1 immediately forces all sync stages, o_filt, filt_q, filter counters and edge_cnt to 0, including mid-filtering or mid-count.
  - While rst is held and after release: o_sync = 0, o_filt = 0, rise = 0, fall = 0, edge_cnt = 0.
  - After release, an input already high produces a normal rise pulse after SYNC_STAGES+FILTER_LEN cycles.
- Total latency from an I change to o_filt is SYNC_STAGES+FILTER_LEN edges (8 with defaults). The rise/fall pulse appears in that same cycle.

Optional Feature:
- Macro IBUF_DEGLITCH_EN.
- Defined: the deglitch filter above is implemented.
- Undefined:
  - No filter counters exist.
  - o_filt is wired combinationally to o_sync, and FILTER_LEN is ignored.
  - Edge detection and counting operate on o_sync.
  - Latency from I to rise becomes SYNC_STAGES edges.

Test Plan:
- Reset, then I=0 held: O=0, o_sync=o_filt=0, rise=fall=0, edge_cnt=0. Set I=1: O=1 combinationally at once; o_sync=1 after 2 edges; o_filt=1 and rise=1 for exactly one cycle after 8 edges; edge_cnt=1.
- With filter enabled: I high for 5 cycles then low (post-sync): o_filt stays 0, no rise, edge_cnt unchanged. A 6-cycle pulse gives o_filt high for 6 cycles, one rise and one fall pulse, and edge_cnt +1.
- Saturation: CNT_WIDTH=4, apply 20 clean pulses: edge_cnt stops at 15. Assert clr coincident with a rise: edge_cnt=0 next cycle.
- WIDTH=2, both bits rise together: rise=2'b11 in one cycle, edge_cnt +1 only. Bit 1 rises alone later: edge_cnt +1 again.
- Assert rst while o_filt=1 and the filter counter is mid-count: all outputs except O go to 0 asynchronously, without waiting for an edge. With I still 1, release rst: rise pulse occurs 8 edges later.
- Build without IBUF_DEGLITCH_EN: a 1-cycle pulse on I after sync yields o_filt=o_sync, one rise and one fall pulse, and edge_cnt +1.

Source files
------------

// File: rtl/ibuf_conditioner_if.sv
// rtl/ibuf_conditioner_if.sv - pad-side and conditioned-view signals of ibuf_conditioner
interface ibuf_conditioner_if #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     I;
    logic [WIDTH-1:0]     O;
    logic [WIDTH-1:0]     o_sync;
    logic [WIDTH-1:0]     o_filt;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;
    logic                 clr;
    logic [CNT_WIDTH-1:0] edge_cnt;

    modport master (
        output I, clr,
        input  O, o_sync, o_filt, rise, fall, edge_cnt
    );

    modport slave (
        input  I, clr,
        output O, o_sync, o_filt, rise, fall, edge_cnt
    );
endinterface

// File: rtl/ibuf_conditioner.sv
// rtl/ibuf_conditioner.sv - pad input buffer with sync, deglitch, edge pulses and edge counter
// Deglitch filter is built only when IBUF_DEGLITCH_EN is defined; otherwise o_filt follows o_sync.
module ibuf_conditioner #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 6,
    parameter int CNT_WIDTH   = 16
) (
    input logic                osc,
    input logic                rst,
    ibuf_conditioner_if.slave  bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ibuf_conditioner: SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("ibuf_conditioner: FILTER_LEN must be at least 1");
    end

    assign bus.O = bus.I;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= bus.I;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign bus.o_sync = sync_q[SYNC_STAGES-1];

`ifdef IBUF_DEGLITCH_EN
    // Counter only needs to reach FILTER_LEN-1; the FILTER_LEN-th mismatch flips o_filt.
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [FCW-1:0]   fcnt [WIDTH];
    logic [WIDTH-1:0] filt_r;

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            filt_r <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                fcnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (bus.o_sync[b] == filt_r[b]) begin
                    fcnt[b] <= '0;
                end else if (fcnt[b] == FCW'(FILTER_LEN - 1)) begin
                    filt_r[b] <= bus.o_sync[b];
                    fcnt[b]   <= '0;
                end else begin
                    fcnt[b] <= fcnt[b] + 1'b1;
                end
            end
        end
    end

    assign bus.o_filt = filt_r;
`else
    assign bus.o_filt = bus.o_sync;
`endif

    logic [WIDTH-1:0] filt_q;

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
        end else begin
            filt_q <= bus.o_filt;
        end
    end

    assign bus.rise = bus.o_filt & ~filt_q;
    assign bus.fall = ~bus.o_filt & filt_q;

    logic [CNT_WIDTH-1:0] cnt_r;

    // Any number of simultaneous rising bits counts as one event; clr wins over increment.
    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (bus.clr) begin
            cnt_r <= '0;
        end else if ((|bus.rise) && !(&cnt_r)) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign bus.edge_cnt = cnt_r;

endmodule

// File: tb/tb_ibuf_conditioner.sv
// tb/tb_ibuf_conditioner.sv - directed and random checks of ibuf_conditioner against a timeline model
module tb_ibuf_conditioner;

    localparam int W  = 2;
    localparam int SS = 2;
    localparam int FL = 6;
    localparam int CW = 4;
`ifdef IBUF_DEGLITCH_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = SS + FL;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = SS;
`endif
    localparam int HMAX = 4096;

    logic osc = 1'b0;
    logic rst;
    always #5 osc = ~osc;

    ibuf_conditioner_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    ibuf_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL), .CNT_WIDTH(CW)
    ) dut (
        .osc(osc),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: per-edge history of sampled inputs and of the synchronized level.
    int          k;
    logic [1:0]  samp_m [HMAX];
    logic [1:0]  s_m    [HMAX];
    logic [1:0]  filt_m, rise_m, fall_m, cur_i;
    int          last_m [2];
    logic [3:0]  cnt_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at k=%0d", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k         = 0;
        s_m[0]    = 2'b00;
        filt_m    = 2'b00;
        rise_m    = 2'b00;
        fall_m    = 2'b00;
        last_m[0] = 0;
        last_m[1] = 0;
        cnt_m     = 4'd0;
    endtask

    // A bit's accepted level flips once the FL sync values preceding this edge all
    // disagree with it and none of them predate its previous flip.
    task automatic model_edge(input logic [1:0] i, input logic c);
        logic [1:0] prev;
        bit         flip;
        k++;
        samp_m[k] = i;
        s_m[k]    = (k >= SS) ? samp_m[k-SS+1] : 2'b00;
        if (c) cnt_m = 4'd0;
        else if (rise_m != 2'b00 && cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
        prev = filt_m;
        if (FILT) begin
            for (int b = 0; b < W; b++) begin
                if (k - FL >= last_m[b]) begin
                    flip = 1'b1;
                    for (int j = k - FL; j < k; j++) begin
                        if (s_m[j][b] == prev[b]) flip = 1'b0;
                    end
                    if (flip) begin
                        filt_m[b] = ~prev[b];
                        last_m[b] = k;
                    end
                end
            end
        end else begin
            filt_m = s_m[k];
        end
        rise_m = filt_m & ~prev;
        fall_m = ~filt_m & prev;
    endtask

    task automatic check_all();
        chk("o_sync",   32'(bus.o_sync),   32'(s_m[k]));
        chk("o_filt",   32'(bus.o_filt),   32'(filt_m));
        chk("rise",     32'(bus.rise),     32'(rise_m));
        chk("fall",     32'(bus.fall),     32'(fall_m));
        chk("edge_cnt", 32'(bus.edge_cnt), 32'(cnt_m));
    endtask

    task automatic step(input logic [1:0] i, input logic c);
        if (k >= HMAX - 2) begin
            $error("FAIL history_bound observed=%0d expected=<%0d", k, HMAX - 2);
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "history overflow");
        end
        bus.I   = i;
        bus.clr = c;
        cur_i   = i;
        #1;
        chk("O_comb", 32'(bus.O), 32'(i));
        @(posedge osc);
        model_edge(i, c);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [1:0] i, input int n);
        for (int t = 0; t < n; t++) step(i, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_o_sync"},   32'(bus.o_sync),   32'd0);
        chk({tag, "_o_filt"},   32'(bus.o_filt),   32'd0);
        chk({tag, "_rise"},     32'(bus.rise),     32'd0);
        chk({tag, "_fall"},     32'(bus.fall),     32'd0);
        chk({tag, "_edge_cnt"}, 32'(bus.edge_cnt), 32'd0);
    endtask

    logic [3:0] c0;
    int         found;

    initial begin
        rst     = 1'b1;
        bus.I   = 2'b00;
        bus.clr = 1'b0;
        model_reset();
        repeat (3) @(posedge osc);
        #1;
        check_zero("reset_held");
        rst = 1'b0;

        // First rise: latency and single-cycle pulse
        hold(2'b00, 4);
        chk("idle_cnt", 32'(bus.edge_cnt), 32'd0);
        hold(2'b01, LAT - 1);
        chk("rise_early", 32'(bus.rise), 32'd0);
        step(2'b01, 1'b0);
        chk("rise_at_lat", 32'(bus.rise), 32'd1);
        step(2'b01, 1'b0);
        chk("rise_one_cycle", 32'(bus.rise), 32'd0);
        chk("first_cnt", 32'(bus.edge_cnt), 32'd1);
        hold(2'b01, 4);
        hold(2'b00, 14);

        // Short glitch: rejected only with the filter
        c0 = bus.edge_cnt;
        hold(2'b01, FL - 1);
        hold(2'b00, 14);
        chk("glitch_cnt", 32'(bus.edge_cnt), 32'(c0 + (FILT ? 4'd0 : 4'd1)));

        // Exactly FL-cycle pulse is accepted
        c0 = bus.edge_cnt;
        hold(2'b01, FL);
        hold(2'b00, 16);
        chk("pulse_fl_cnt", 32'(bus.edge_cnt), 32'(c0 + 4'd1));

        // Saturation
        for (int p = 0; p < 20; p++) begin
            hold(2'b01, FL + 2);
            hold(2'b00, FL + 2);
        end
        hold(2'b00, LAT + 2);
        chk("saturate", 32'(bus.edge_cnt), 32'd15);

        // clr coincident with a rise
        found = 0;
        for (int t = 0; t < 3 * LAT && found == 0; t++) begin
            step(2'b01, 1'b0);
            if (rise_m != 2'b00) found = 1;
        end
        chk("clr_rise_found", 32'(found), 32'd1);
        chk("clr_rise_pending", 32'(bus.rise), 32'd1);
        step(2'b01, 1'b1);
        chk("clr_overrides", 32'(bus.edge_cnt), 32'd0);
        hold(2'b01, 3);
        hold(2'b00, 16);

        // Both bits together count once, bit 1 alone counts again
        c0 = bus.edge_cnt;
        hold(2'b11, LAT + 4);
        chk("both_cnt", 32'(bus.edge_cnt), 32'(c0 + 4'd1));
        hold(2'b00, 16);
        c0 = bus.edge_cnt;
        hold(2'b10, LAT + 4);
        chk("bit1_cnt", 32'(bus.edge_cnt), 32'(c0 + 4'd1));
        hold(2'b00, 16);

        // Random pulse trains
        for (int r = 0; r < 120; r++) begin
            hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 10)));
            if ((r % 40) == 39) step(cur_i, 1'b1);
        end

        // Asynchronous reset while filtered high and mid-count
        hold(2'b11, LAT + 4);
        hold(2'b00, 3);
        #1;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        chk("async_rst_O", 32'(bus.O), 32'd0);
        repeat (2) @(posedge osc);
        #1;
        bus.I = 2'b11;
        #1;
        chk("rst_O_comb", 32'(bus.O), 32'd3);
        check_zero("rst_held_high_in");
        @(posedge osc);
        #1;
        rst = 1'b0;
        model_reset();
        hold(2'b11, LAT - 1);
        chk("post_rst_early", 32'(bus.rise), 32'd0);
        step(2'b11, 1'b0);
        chk("post_rst_rise", 32'(bus.rise), 32'd3);
        hold(2'b11, 2);
        chk("post_rst_cnt", 32'(bus.edge_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
